// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// Frame controller for the UART transmit path. Accepts a parallel word through a
// valid/ready handshake, drives an external MSB-first Serializer (load + shift
// pulses) and frames the TX line as: start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, one stop bit.
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst         asynchronous reset, active low
//   i_data        parallel word to transmit
//   i_data_valid  word available; accepted when i_data_valid && o_ready
//   o_ready       idle, can accept a word
//   i_par_en      1 = insert parity bit (sampled at accept)
//   i_par_type    0 = even, 1 = odd (sampled at accept)
//   o_ser_data    bit-reversed captured word, to Serializer data input
//   o_ser_load    Serializer load enable (one cycle, last cycle of START)
//   o_ser_shift   Serializer shift enable (last cycle of each data bit but the last)
//   i_ser_bit     Serializer output (current MSB)
//   o_tx          UART TX line, idle high
//   o_busy        frame in progress
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    output logic                  o_ready,
    input  logic                  i_par_en,
    input  logic                  i_par_type,
    output logic [DATA_WIDTH-1:0] o_ser_data,
    output logic                  o_ser_load,
    output logic                  o_ser_shift,
    input  logic                  i_ser_bit,
    output logic                  o_tx,
    output logic                  o_busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Reverse bit order so the LSB of the word leaves the MSB-first Serializer first.
    function automatic logic [DATA_WIDTH-1:0] bit_reverse(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            r[i] = d[DATA_WIDTH-1-i];
        end
        return r;
    endfunction

    // Even parity is the XOR reduction; odd parity is its inverse.
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    state_t                state_r;
    state_t                state_nx_s;
    logic [BAUD_W-1:0]     baud_cnt_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [DATA_WIDTH-1:0] ser_data_r;
    logic                  par_en_r;
    logic                  par_bit_r;   // already folds in the parity type sampled at accept
    logic                  baud_last_s;
    logic                  bit_last_s;

    assign baud_last_s = (baud_cnt_r == BAUD_W'(CLKS_PER_BIT - 1));
    assign bit_last_s  = (bit_cnt_r == BIT_W'(DATA_WIDTH - 1));

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: every non-idle state lasts one full baud period.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (i_data_valid) state_nx_s = S_START;
                else              state_nx_s = S_IDLE;
            end
            S_START: begin
                if (baud_last_s) state_nx_s = S_DATA;
                else             state_nx_s = S_START;
            end
            S_DATA: begin
                if (baud_last_s && bit_last_s) state_nx_s = par_en_r ? S_PARITY : S_STOP;
                else                           state_nx_s = S_DATA;
            end
            S_PARITY: begin
                if (baud_last_s) state_nx_s = S_STOP;
                else             state_nx_s = S_PARITY;
            end
            S_STOP: begin
                if (baud_last_s) state_nx_s = S_IDLE;
                else             state_nx_s = S_STOP;
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Baud counter: runs in non-idle states, cleared on every state change.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            baud_cnt_r <= '0;
        end else if ((state_nx_s != state_r) || (state_r == S_IDLE)) begin
            baud_cnt_r <= '0;
        end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
        end
    end

    // Data bit counter: advances at the end of each data bit period.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            bit_cnt_r <= '0;
        end else if ((state_r == S_DATA) && baud_last_s) begin
            bit_cnt_r <= bit_last_s ? '0 : (bit_cnt_r + BIT_W'(1));
        end else if (state_r != S_DATA) begin
            bit_cnt_r <= '0;
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Capture word and parity settings on the accept edge; held for the whole frame.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ser_data_r <= '0;
            par_en_r   <= 1'b0;
            par_bit_r  <= 1'b0;
        end else if ((state_r == S_IDLE) && i_data_valid) begin
            ser_data_r <= bit_reverse(i_data);
            par_en_r   <= i_par_en;
            par_bit_r  <= parity_bit(i_data, i_par_type);
        end else begin
            ser_data_r <= ser_data_r;
            par_en_r   <= par_en_r;
            par_bit_r  <= par_bit_r;
        end
    end

    // Output decode from registered state only, so reset takes the line high at once.
    always_comb begin
        o_ready     = (state_r == S_IDLE);
        o_busy      = (state_r != S_IDLE);
        o_ser_load  = (state_r == S_START) && baud_last_s;
        o_ser_shift = (state_r == S_DATA) && baud_last_s && !bit_last_s;
        o_tx        = 1'b1;
        case (state_r)
            S_IDLE:   o_tx = 1'b1;
            S_START:  o_tx = 1'b0;
            S_DATA:   o_tx = i_ser_bit;
            S_PARITY: o_tx = par_bit_r;
            S_STOP:   o_tx = 1'b1;
            default:  o_tx = 1'b1;
        endcase
    end

    assign o_ser_data = ser_data_r;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

    localparam int DW  = 8;
    localparam int CPB = 4;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [DW-1:0] i_data;
    logic          i_data_valid;
    logic          o_ready;
    logic          i_par_en;
    logic          i_par_type;
    logic [DW-1:0] o_ser_data;
    logic          o_ser_load;
    logic          o_ser_shift;
    logic          i_ser_bit;
    logic          o_tx;
    logic          o_busy;

    int checks = 0;
    int errors = 0;

    uart_tx_ctrl #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_data_valid(i_data_valid),
        .o_ready(o_ready), .i_par_en(i_par_en), .i_par_type(i_par_type),
        .o_ser_data(o_ser_data), .o_ser_load(o_ser_load), .o_ser_shift(o_ser_shift),
        .i_ser_bit(i_ser_bit), .o_tx(o_tx), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural MSB-first Serializer the controller drives.
    logic [DW-1:0] ser_model = '0;
    always @(posedge i_clk) begin
        if (o_ser_load)       ser_model <= o_ser_data;
        else if (o_ser_shift) ser_model <= {ser_model[DW-2:0], 1'b0};
    end
    assign i_ser_bit = ser_model[DW-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of the first START cycle; returns at the negedge of the
    // first IDLE cycle after the frame.
    task automatic check_frame(input logic [DW-1:0] d, input logic pen, input logic ptype,
                               input bit mutate);
        logic       bits [0:DW+2];
        logic [DW-1:0] rev;
        int nslots, loads, shifts, busy_cnt, slot, phase;
        nslots = DW + 2 + (pen ? 1 : 0);
        bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) bits[1+i] = d[i];
        if (pen) bits[DW+1] = (($countones(d) % 2) == 1) ^ ptype;
        bits[nslots-1] = 1'b1;
        for (int i = 0; i < DW; i++) rev[i] = d[DW-1-i];
        chk("ser_data", o_ser_data, rev);
        loads = 0; shifts = 0; busy_cnt = 0;
        for (int c = 0; c < nslots*CPB; c++) begin
            slot  = c / CPB;
            phase = c % CPB;
            chk($sformatf("tx c%0d", c), o_tx, bits[slot]);
            chk("busy", o_busy, 1'b1);
            chk("load", o_ser_load, (slot == 0) && (phase == CPB-1));
            chk("shift", o_ser_shift, (slot >= 1) && (slot <= DW-1) && (phase == CPB-1));
            loads    += o_ser_load;
            shifts   += o_ser_shift;
            busy_cnt += o_busy;
            if (mutate && slot >= 1 && slot <= DW) begin
                i_data     = DW'($urandom);
                i_par_en   = ~i_par_en;
                i_par_type = 1'($urandom);
            end
            @(negedge i_clk);
        end
        chk("load_count", loads, 1);
        chk("shift_count", shifts, DW-1);
        chk("busy_cycles", busy_cnt, nslots*CPB);
        chk("idle_tx", o_tx, 1'b1);
        chk("idle_busy", o_busy, 1'b0);
        chk("idle_ready", o_ready, 1'b1);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic pen, input logic ptype,
                        input bit mutate);
        i_data = d; i_par_en = pen; i_par_type = ptype; i_data_valid = 1'b1;
        chk("ready_before", o_ready, 1'b1);
        @(negedge i_clk);
        i_data_valid = 1'b0;
        check_frame(d, pen, ptype, mutate);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic pen, ptype;

        // 1. Reset held with valid asserted.
        i_rst = 1'b0; i_data = 8'h5A; i_data_valid = 1'b1; i_par_en = 1'b0; i_par_type = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            chk("rst_tx", o_tx, 1'b1);
            chk("rst_ready", o_ready, 1'b1);
            chk("rst_busy", o_busy, 1'b0);
            chk("rst_load", o_ser_load, 1'b0);
            chk("rst_shift", o_ser_shift, 1'b0);
            chk("rst_ser_data", o_ser_data, 8'h00);
        end
        i_data_valid = 1'b0;
        i_rst = 1'b1;
        @(negedge i_clk);

        // 2. 0x35, no parity.
        send(8'h35, 1'b0, 1'b0, 1'b0);
        chk("ser_data_35", o_ser_data, 8'hAC);

        // 3. 0x35 with even then odd parity.
        send(8'h35, 1'b1, 1'b0, 1'b0);
        send(8'h35, 1'b1, 1'b1, 1'b0);

        // 4. Back-to-back with valid held high: one idle cycle between frames.
        i_data = 8'h01; i_par_en = 1'b0; i_par_type = 1'b0; i_data_valid = 1'b1;
        @(negedge i_clk);
        i_data = 8'h80;
        check_frame(8'h01, 1'b0, 1'b0, 1'b0);
        @(negedge i_clk);
        i_data_valid = 1'b0;
        check_frame(8'h80, 1'b0, 1'b0, 1'b0);

        // 5. Reset during data bit 3, then a clean 0xFF frame.
        i_data = 8'h3C; i_data_valid = 1'b1;
        @(negedge i_clk);
        i_data_valid = 1'b0;
        repeat ((1 + 3) * CPB + 1) @(negedge i_clk);
        chk("pre_abort_busy", o_busy, 1'b1);
        #1 i_rst = 1'b0;
        #1;
        chk("abort_tx", o_tx, 1'b1);
        chk("abort_ready", o_ready, 1'b1);
        chk("abort_busy", o_busy, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        send(8'hFF, 1'b0, 1'b0, 1'b0);

        // 6. Inputs disturbed mid-frame, both parity settings.
        send(8'h35, 1'b1, 1'b1, 1'b1);
        send(8'hC3, 1'b0, 1'b1, 1'b1);

        // Randomized frames against the frame model.
        for (int n = 0; n < 24; n++) begin
            d     = DW'($urandom);
            pen   = 1'($urandom);
            ptype = 1'($urandom);
            send(d, pen, ptype, bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
